matrix_stream_loader: RTL

- Front end that drives the 4x4 systolic multiplier's input port, on the initiator side of its i_a/i_b/i_validInput/o_validResult interface.
- Accepts a byte stream with valid/ready handshake and assembles matrix A, then matrix B, into a load buffer.
- Issues one registered validInput pulse with A/B held stable, then tracks the array as busy until its result pulse returns.
- One-deep double buffering: the next A/B pair streams in while the array computes.

---
 rtl/systolic_pkg.sv | 19 +
 rtl/matrix_load_buffer.sv | 37 +++
 rtl/matrix_stream_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared constants, element/matrix types and loader FSM states for the systolic front end.
package systolic_pkg;

    localparam int unsigned DW    = 8;
    localparam int unsigned N     = 4;
    localparam int unsigned NELEM = 2 * N * N;
    localparam int unsigned HALF  = N * N;
    localparam int unsigned IDX_W = $clog2(NELEM);
    localparam int unsigned RC_W  = $clog2(N);

    typedef logic [DW-1:0] elem_t;
    typedef elem_t [N-1:0][N-1:0] matrix_t;

    typedef enum logic {
        S_FILL,
        S_FULL
    } state_t;

endpackage

// File: rtl/matrix_load_buffer.sv
// Write-indexed staging buffer: stream index 0..15 fills A, 16..31 fills B, row-major.
module matrix_load_buffer
    import systolic_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  elem_t            data,
    output matrix_t          a,
    output matrix_t          b
);

    logic            sel_b;
    logic [RC_W-1:0] row;
    logic [RC_W-1:0] col;

    // Top index bit picks the matrix, the remaining bits give row and column.
    assign sel_b = idx[IDX_W-1];
    assign row   = idx[2*RC_W-1:RC_W];
    assign col   = idx[RC_W-1:0];

    // Store one element per accepted write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= '0;
            b <= '0;
        end else if (we) begin
            if (sel_b) begin
                b[row][col] <= data;
            end else begin
                a[row][col] <= data;
            end
        end
    end

endmodule

// File: rtl/matrix_stream_loader.sv
// Byte-stream front end for the 4x4 systolic array: frames A/B, issues them, tracks busy.
module matrix_stream_loader
    import systolic_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_arst,
    input  elem_t   i_data,
    input  logic    i_valid,
    input  logic    i_last,
    output logic    o_ready,
    output matrix_t o_a,
    output matrix_t o_b,
    output logic    o_validInput,
    input  logic    i_validResult,
    output logic    o_busy,
    output logic    o_error,
    input  logic    i_clearError
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             issue_c;
    logic             we_c;
    logic             xfer_c;
    logic             at_last_c;
    logic             frame_err_c;
    matrix_t          buf_a, buf_b;

    matrix_load_buffer u_buf (
        .clk  (i_clk),
        .rst  (i_arst),
        .we   (we_c),
        .idx  (idx_q),
        .data (i_data),
        .a    (buf_a),
        .b    (buf_b)
    );

    // Ready is a pure decode of the state register.
    assign o_ready = (state_q == S_FILL);
    assign o_busy  = busy_q;
    assign o_error = err_q;

    // State, index, busy and error registers.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= S_FILL;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Next-state: framing checks while filling, issue arbitration when full.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        err_d       = err_q;
        issue_c     = 1'b0;
        we_c        = 1'b0;
        xfer_c      = i_valid && (state_q == S_FILL);
        at_last_c   = (idx_q == IDX_W'(NELEM - 1));
        frame_err_c = xfer_c && (i_last != at_last_c);

        case (state_q)
            S_FILL: begin
                if (xfer_c) begin
                    if (frame_err_c) begin
                        idx_d = '0;
                    end else begin
                        we_c = 1'b1;
                        if (at_last_c) begin
                            idx_d   = '0;
                            state_d = S_FULL;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            S_FULL: begin
                if (!busy_q || i_validResult) begin
                    issue_c = 1'b1;
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase

        // A result retiring in the issue cycle leaves the array busy with the new op.
        if (issue_c) begin
            busy_d = 1'b1;
        end else if (i_validResult) begin
            busy_d = 1'b0;
        end

        // A new framing error outranks a simultaneous clear.
        if (frame_err_c) begin
            err_d = 1'b1;
        end else if (i_clearError) begin
            err_d = 1'b0;
        end
    end

    // Operand and issue-pulse registers; operands move only on issue.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_a          <= '0;
            o_b          <= '0;
            o_validInput <= 1'b0;
        end else begin
            o_validInput <= issue_c;
            if (issue_c) begin
                o_a <= buf_a;
                o_b <= buf_b;
            end
        end
    end

endmodule
